// File: rtl/phy_tx_pkg.sv
// Shared definitions for the two-lane PHY transmit scheduler.
//   sched_state_e      : scheduler state encoding, also driven on lane_tx_sched.state
//   IDLE_SYM_DEFAULT   : comma/idle byte sent on a lane that has no data
//   TRAIN_LEN_DEFAULT  : idle symbols sent on both lanes before data is released
//   NUM_LANES          : number of independent byte lanes
package phy_tx_pkg;

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_PAUSE  = 2'd3
  } sched_state_e;

  localparam logic [7:0] IDLE_SYM_DEFAULT  = 8'hBC;
  localparam int         TRAIN_LEN_DEFAULT = 4;
  localparam int         NUM_LANES         = 2;

endpackage

// File: rtl/lane_fifo.sv
// Synchronous single-clock FIFO buffering bytes for one transmit lane.
//   clk   : clock, all state updates on its rising edge
//   clr   : synchronous clear of pointers and count (active high)
//   push  : write din at the tail (ignored when full)
//   pop   : drop the head entry (ignored when empty)
//   din   : write data
//   head  : oldest entry, valid whenever empty = 0
//   full  : count == DEPTH
//   empty : count == 0
//   count : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module lane_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Push and pop together leave the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q alone says which entries hold live data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/lane_tx_sched.sv
// Two-lane transmit scheduler: trains the link with idle symbols, then
// drains one byte per lane per cycle from per-lane FIFOs into registered
// outputs. Lanes drain independently; a pause sends idles and keeps data.
//   clk_2f                   : byte-rate clock
//   reset                    : synchronous, active-high reset
//   enable                   : 1 = transmit, 0 = pause
//   validin0/1, entrada_0/1  : input byte and qualifier per lane
//   ready0/1                 : lane FIFO can take a byte this cycle
//   data_out_0/1             : registered byte to the lane serializer
//   valid_out_0/1            : 1 = data byte, 0 = idle symbol
//   state                    : current scheduler state (sched_state_e)
//   overflow                 : sticky, set when a byte arrives at a full lane
module lane_tx_sched
  import phy_tx_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         TRAIN_LEN  = TRAIN_LEN_DEFAULT,
  parameter logic [7:0] IDLE_SYM   = IDLE_SYM_DEFAULT
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic       enable,
  input  logic       validin0,
  input  logic       validin1,
  input  logic [7:0] entrada_0,
  input  logic [7:0] entrada_1,
  output logic       ready0,
  output logic       ready1,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic [1:0] state,
  output logic       overflow
);

  localparam int         CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_LEN - 1);

  sched_state_e state_q, state_d;
  logic [7:0]   train_cnt_q, train_cnt_d;
  logic         overflow_q, overflow_d;

  logic [NUM_LANES-1:0][7:0]       data_out_q, data_out_d;
  logic [NUM_LANES-1:0]            valid_out_q, valid_out_d;
  logic [NUM_LANES-1:0]            validin, ready, push, pop, full, empty;
  logic [NUM_LANES-1:0][7:0]       din, head;
  logic [NUM_LANES-1:0][CNT_W-1:0] count;

  assign validin = {validin1, validin0};
  assign din     = {entrada_1, entrada_0};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    // Lanes never accept data while the scheduler is held in RST.
    assign ready[i] = (state_q != ST_RST) & ~full[i];
    assign push[i]  = validin[i] & ready[i];
    assign pop[i]   = (state_q == ST_ACTIVE) & ~empty[i];

    lane_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
    ) u_fifo (
      .clk   (clk_2f),
      .clr   (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (din[i]),
      .head  (head[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (count[i])
    );

    // The flags and the count describe the same occupancy.
    always_comb begin
      assert (empty[i] == (count[i] == '0));
    end
  end

  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    overflow_d  = overflow_q | (|(validin & full));

    // Output registers reload every cycle: head byte when popping, idle otherwise.
    for (int i = 0; i < NUM_LANES; i++) begin
      data_out_d[i]  = IDLE_SYM;
      valid_out_d[i] = 1'b0;
      if (pop[i]) begin
        data_out_d[i]  = head[i];
        valid_out_d[i] = 1'b1;
      end
    end

    case (state_q)
      ST_RST: begin
        if (enable) begin
          state_d     = ST_TRAIN;
          train_cnt_d = '0;
        end
      end
      ST_TRAIN: begin
        if (!enable) begin
          state_d = ST_PAUSE;
        end else if (train_cnt_q == TRAIN_LAST) begin
          state_d     = ST_ACTIVE;
          train_cnt_d = '0;
        end else begin
          train_cnt_d = train_cnt_q + 8'd1;
        end
      end
      ST_ACTIVE: begin
        if (!enable) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        // Resuming always retrains the link from a fresh count.
        if (enable) begin
          state_d     = ST_TRAIN;
          train_cnt_d = '0;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q     <= ST_RST;
      train_cnt_q <= '0;
      overflow_q  <= 1'b0;
      data_out_q  <= {NUM_LANES{IDLE_SYM}};
      valid_out_q <= '0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      overflow_q  <= overflow_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign ready0      = ready[0];
  assign ready1      = ready[1];
  assign data_out_0  = data_out_q[0];
  assign data_out_1  = data_out_q[1];
  assign valid_out_0 = valid_out_q[0];
  assign valid_out_1 = valid_out_q[1];
  assign state       = state_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_lane_tx_sched.sv
// Self-checking bench for lane_tx_sched: directed steps in one initial
// block, a per-lane scoreboard queue filled when bytes are accepted and
// drained when the scheduler is expected to emit them.
module tb_lane_tx_sched;
  import phy_tx_pkg::*;

  localparam int         DEPTH = 4;
  localparam int         TLEN  = 4;
  localparam logic [7:0] IDLE  = 8'hBC;

  logic       clk_2f = 1'b0;
  logic       reset, enable, validin0, validin1;
  logic [7:0] entrada_0, entrada_1;
  logic       ready0, ready1, valid_out_0, valid_out_1, overflow;
  logic [7:0] data_out_0, data_out_1;
  logic [1:0] state;

  lane_tx_sched #(
    .FIFO_DEPTH (DEPTH),
    .TRAIN_LEN  (TLEN),
    .IDLE_SYM   (IDLE)
  ) dut (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .enable      (enable),
    .validin0    (validin0),
    .validin1    (validin1),
    .entrada_0   (entrada_0),
    .entrada_1   (entrada_1),
    .ready0      (ready0),
    .ready1      (ready1),
    .data_out_0  (data_out_0),
    .data_out_1  (data_out_1),
    .valid_out_0 (valid_out_0),
    .valid_out_1 (valid_out_1),
    .state       (state),
    .overflow    (overflow)
  );

  always #5 clk_2f = ~clk_2f;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  // Reference state: scheduler state, training count, sticky flag, lane queues.
  logic [1:0] m_state = 2'd0;
  int         m_cnt   = 0;
  logic       m_ovf   = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1);
    enable    = en;
    validin0  = v0;
    entrada_0 = d0;
    validin1  = v1;
    entrada_1 = d1;
  endtask

  // Advance one edge: update the reference from the inputs now applied,
  // then compare every output 1 time unit after the edge.
  task automatic tick();
    logic [7:0] e_d0, e_d1;
    logic       e_v0, e_v1, r0, r1;
    e_d0 = IDLE;
    e_d1 = IDLE;
    e_v0 = 1'b0;
    e_v1 = 1'b0;
    if (reset) begin
      q0.delete();
      q1.delete();
      m_state = ST_RST;
      m_cnt   = 0;
      m_ovf   = 1'b0;
    end else begin
      r0 = (m_state != ST_RST) && (q0.size() < DEPTH);
      r1 = (m_state != ST_RST) && (q1.size() < DEPTH);
      if (validin0 && q0.size() >= DEPTH) m_ovf = 1'b1;
      if (validin1 && q1.size() >= DEPTH) m_ovf = 1'b1;
      if (m_state == ST_ACTIVE && q0.size() > 0) begin e_d0 = q0.pop_front(); e_v0 = 1'b1; end
      if (m_state == ST_ACTIVE && q1.size() > 0) begin e_d1 = q1.pop_front(); e_v1 = 1'b1; end
      if (validin0 && r0) q0.push_back(entrada_0);
      if (validin1 && r1) q1.push_back(entrada_1);
      case (m_state)
        ST_RST:    if (enable) begin m_state = ST_TRAIN; m_cnt = 0; end
        ST_TRAIN:  if (!enable) m_state = ST_PAUSE;
                   else if (m_cnt == TLEN - 1) begin m_state = ST_ACTIVE; m_cnt = 0; end
                   else m_cnt++;
        ST_ACTIVE: if (!enable) m_state = ST_PAUSE;
        default:   if (enable) begin m_state = ST_TRAIN; m_cnt = 0; end
      endcase
    end
    @(posedge clk_2f);
    #1;
    check("state",       32'(state),       32'(m_state));
    check("data_out_0",  32'(data_out_0),  32'(e_d0));
    check("data_out_1",  32'(data_out_1),  32'(e_d1));
    check("valid_out_0", 32'(valid_out_0), 32'(e_v0));
    check("valid_out_1", 32'(valid_out_1), 32'(e_v1));
    check("overflow",    32'(overflow),    32'(m_ovf));
    check("ready0", 32'(ready0), 32'((m_state != ST_RST) && (q0.size() < DEPTH)));
    check("ready1", 32'(ready1), 32'((m_state != ST_RST) && (q1.size() < DEPTH)));
  endtask

  initial begin
    logic [1:0] train_seq [5];
    logic [7:0] burst [4];
    logic [7:0] got1[$];
    int v0_seen, v1_seen;
    train_seq = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    burst     = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

    // Reset state.
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_ready", 32'({ready1, ready0}), 32'd0);
    check("rst_data",  32'({data_out_1, data_out_0}), 32'hBCBC);

    // Held in RST while enable is low after reset release.
    reset = 1'b0;
    tick();
    check("hold_rst", 32'(state), 32'd0);

    // Enable: TRAIN for exactly TRAIN_LEN cycles, then ACTIVE, idles throughout.
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("train_seq", 32'(state), 32'(train_seq[i]));
      check("train_idle", 32'({valid_out_1, valid_out_0, data_out_1, data_out_0}), 32'h0000BCBC);
    end

    // Lane 0 burst 01,02,03 with one-cycle latency; lane 1 stays idle.
    drive(1'b1, 1'b1, 8'h01, 1'b0, 8'h00);
    tick();
    check("lat_first_edge", 32'(valid_out_0), 32'd0);
    drive(1'b1, 1'b1, 8'h02, 1'b0, 8'h00);
    tick();
    check("lat_byte01", 32'({valid_out_0, data_out_0}), 32'h101);
    drive(1'b1, 1'b1, 8'h03, 1'b0, 8'h00);
    tick();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    tick();

    // Pause, fill lane 1, then a fifth byte into the full FIFO.
    enable = 1'b0;
    tick();
    check("pause_state", 32'(state), 32'd3);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, burst[i]);
      tick();
    end
    check("full_ready1", 32'(ready1), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'hA5);
    tick();
    check("ovf_set", 32'(overflow), 32'd1);

    // Resume: retrain, then the four buffered bytes in order, A5 never.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid_out_1) got1.push_back(data_out_1);
    end
    check("burst_count", 32'(got1.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("burst_byte", 32'((i < got1.size()) ? got1[i] : 8'h00), 32'(burst[i]));

    // Continuous push/pop on both lanes across several pointer wraps.
    v0_seen = 0;
    v1_seen = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 8'(8'h40 + i), 1'b1, 8'(8'h80 + i));
      tick();
      if (valid_out_0) v0_seen++;
      if (valid_out_1) v1_seen++;
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    if (valid_out_0) v0_seen++;
    if (valid_out_1) v1_seen++;
    check("stream_lane0", 32'(v0_seen), 32'd20);
    check("stream_lane1", 32'(v1_seen), 32'd20);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Queue three bytes, then reset mid-stream: they must never appear.
    enable = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 8'h00);
      tick();
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    reset = 1'b1;
    tick();
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_out", 32'({valid_out_1, valid_out_0, data_out_1, data_out_0}), 32'h0000BCBC);
    check("mid_rst_ready", 32'({ready1, ready0}), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    v0_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_out_0) v0_seen++;
    end
    check("flushed_lane0", 32'(v0_seen), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
